// File: rtl/dram_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module   : dram_cmd_responder
// Brief    : Single-row DRAM device model: ACT/READ/WRITE/PRE decode, tRCD/tRP
//            enforcement and CAS-latency read return with a one-cycle strobe.
// Revision : 1.0 - initial release
// ============================================================================
module dram_cmd_responder #(
    parameter int DATA_BITS     = 32,
    parameter int ROW_BITS      = 11,
    parameter int COL_BITS      = 10,
    parameter int MEM_ADDR_BITS = 12,
    parameter int T_RCD         = 5,
    parameter int T_RP          = 5,
    parameter int CAS_LAT       = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   DRAM_CSn,
    input  logic                   DRAM_RASn,
    input  logic                   DRAM_CASn,
    input  logic [DATA_BITS/8-1:0] DRAM_WEn,
    input  logic [ROW_BITS-1:0]    DRAM_A,
    input  logic [DATA_BITS-1:0]   DRAM_D,
    output logic [DATA_BITS-1:0]   DRAM_Q,
    output logic                   DRAM_valid,
    output logic                   cmd_err
);

    localparam int c_LANES = DATA_BITS / 8;
    localparam int c_DEPTH = 1 << MEM_ADDR_BITS;
    localparam int c_T_MAX = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int c_CNT_W = (c_T_MAX > 1) ? $clog2(c_T_MAX) : 1;

    localparam logic [1:0] c_ST_CLOSED      = 2'd0;
    localparam logic [1:0] c_ST_ACTIVATING  = 2'd1;
    localparam logic [1:0] c_ST_OPEN        = 2'd2;
    localparam logic [1:0] c_ST_PRECHARGING = 2'd3;

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [c_CNT_W-1:0]       r_cnt;
    logic [c_CNT_W-1:0]       w_cnt_nxt;
    logic [ROW_BITS-1:0]      r_row;
    logic [ROW_BITS-1:0]      w_row_nxt;

    logic                     w_we_all1;
    logic                     w_we_all0;
    logic                     w_sel;
    logic                     w_is_act;
    logic                     w_is_pre;
    logic                     w_is_rd;
    logic                     w_is_wr;
    logic                     w_is_nop;
    logic                     w_is_bad;
    logic                     w_rd_acc;
    logic                     w_wr_acc;
    logic                     w_err;

    logic [ROW_BITS+COL_BITS-1:0] w_full_addr;
    logic [MEM_ADDR_BITS-1:0]     w_idx;
    logic                         w_unused_bits;

    logic [DATA_BITS-1:0]     r_mem [c_DEPTH];
    logic [DATA_BITS-1:0]     r_pd  [CAS_LAT];
    logic [CAS_LAT-1:0]       r_pv;

    // Command decode; a deselected bus is always a NOP.
    assign w_we_all1 = &DRAM_WEn;
    assign w_we_all0 = ~|DRAM_WEn;
    assign w_sel     = ~DRAM_CSn;
    assign w_is_act  = w_sel & ~DRAM_RASn &  DRAM_CASn & w_we_all1;
    assign w_is_pre  = w_sel & ~DRAM_RASn &  DRAM_CASn & w_we_all0;
    assign w_is_rd   = w_sel &  DRAM_RASn & ~DRAM_CASn & w_we_all1;
    assign w_is_wr   = w_sel &  DRAM_RASn & ~DRAM_CASn & ~w_we_all1;
    assign w_is_nop  = ~w_sel | (DRAM_RASn & DRAM_CASn);
    assign w_is_bad  = w_sel & ~DRAM_RASn & (~DRAM_CASn | (~w_we_all1 & ~w_we_all0));

    assign w_full_addr   = {r_row, DRAM_A[COL_BITS-1:0]};
    assign w_idx         = w_full_addr[MEM_ADDR_BITS-1:0];
    assign w_unused_bits = ^{DRAM_A, w_full_addr};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_CLOSED;
            r_cnt   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_row   <= w_row_nxt;
        end
    end

    // Leaving the wait state on the last count makes the command at ACT+T_RCD
    // (or PRE+T_RP) the first one accepted.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_row_nxt   = r_row;
        case (r_state)
            c_ST_CLOSED: begin
                if (w_is_act) begin
                    w_row_nxt   = DRAM_A;
                    w_cnt_nxt   = c_CNT_W'(T_RCD - 1);
                    w_state_nxt = (T_RCD > 1) ? c_ST_ACTIVATING : c_ST_OPEN;
                end
            end
            c_ST_ACTIVATING: begin
                if (r_cnt <= c_CNT_W'(1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_OPEN;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
            c_ST_OPEN: begin
                if (w_is_pre) begin
                    w_cnt_nxt   = c_CNT_W'(T_RP - 1);
                    w_state_nxt = (T_RP > 1) ? c_ST_PRECHARGING : c_ST_CLOSED;
                end
            end
            default: begin
                if (r_cnt <= c_CNT_W'(1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_CLOSED;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        w_rd_acc = 1'b0;
        w_wr_acc = 1'b0;
        w_err    = w_is_bad;
        case (r_state)
            c_ST_CLOSED: begin
                if (w_is_rd || w_is_wr) w_err = 1'b1;
            end
            c_ST_OPEN: begin
                w_rd_acc = w_is_rd;
                w_wr_acc = w_is_wr;
                if (w_is_act) w_err = 1'b1;
            end
            default: begin
                if (!w_is_nop) w_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            for (int i = 0; i < c_LANES; i++) begin
                if (!DRAM_WEn[i]) r_mem[w_idx][i*8 +: 8] <= DRAM_D[i*8 +: 8];
            end
        end
    end

    // Stage 0 captures the word at the command edge, so a later write to the
    // same index cannot disturb a read already in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pv       <= '0;
            for (int i = 0; i < CAS_LAT; i++) r_pd[i] <= '0;
            DRAM_Q     <= '0;
            DRAM_valid <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            r_pv[0] <= w_rd_acc;
            r_pd[0] <= r_mem[w_idx];
            for (int i = 1; i < CAS_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pd[i] <= r_pd[i-1];
            end
            DRAM_valid <= r_pv[CAS_LAT-1];
            if (r_pv[CAS_LAT-1]) DRAM_Q <= r_pd[CAS_LAT-1];
            cmd_err <= w_err;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dram_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_cmd_responder
// Brief    : Scoreboard bench for dram_cmd_responder: directed scenarios plus
//            random command traffic against a timestamp-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_cmd_responder;

    localparam int DATA_BITS     = 32;
    localparam int ROW_BITS      = 11;
    localparam int COL_BITS      = 10;
    localparam int MEM_ADDR_BITS = 12;
    localparam int T_RCD         = 5;
    localparam int T_RP          = 5;
    localparam int CAS_LAT       = 5;
    localparam int LANES         = DATA_BITS / 8;

    typedef enum int {K_NOP, K_DESEL, K_ACT, K_RD, K_WR, K_PRE, K_BAD_RC, K_BAD_WE} kind_t;

    typedef struct {
        int                   due;
        logic [DATA_BITS-1:0] data;
    } rd_t;

    logic                 clk  = 1'b0;
    logic                 rst  = 1'b0;
    logic                 csn  = 1'b1;
    logic                 rasn = 1'b1;
    logic                 casn = 1'b1;
    logic [LANES-1:0]     wen  = '1;
    logic [ROW_BITS-1:0]  a    = '0;
    logic [DATA_BITS-1:0] d    = '0;
    logic [DATA_BITS-1:0] q;
    logic                 valid;
    logic                 err;

    always #5 clk = ~clk;

    dram_cmd_responder #(
        .DATA_BITS(DATA_BITS), .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS),
        .MEM_ADDR_BITS(MEM_ADDR_BITS), .T_RCD(T_RCD), .T_RP(T_RP), .CAS_LAT(CAS_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .DRAM_CSn(csn), .DRAM_RASn(rasn), .DRAM_CASn(casn), .DRAM_WEn(wen),
        .DRAM_A(a), .DRAM_D(d),
        .DRAM_Q(q), .DRAM_valid(valid), .cmd_err(err)
    );

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference model: open-row flag plus timestamps of the last accepted ACT/PRE.
    rd_t                  exp_rd[$];
    bit                   exp_err[int];
    logic [DATA_BITS-1:0] mem_m[int];
    logic [DATA_BITS-1:0] exp_q = '0;
    bit                   m_open = 1'b0;
    int                   m_row = 0;
    int                   m_act_t = -1000;
    int                   m_pre_t = -1000;

    int compared   = 0;
    int mismatched = 0;

    function automatic int idx_of(int row, int acol);
        return ((row << COL_BITS) | (acol % (1 << COL_BITS))) % (1 << MEM_ADDR_BITS);
    endfunction

    task automatic chk(string name, logic [DATA_BITS-1:0] act, logic [DATA_BITS-1:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s @edge %0d: got %h expected %h", name, edge_cnt, act, expv);
        end
    endtask

    task automatic issue(kind_t k, int av, logic [DATA_BITS-1:0] dv, logic [LANES-1:0] wv);
        int                   e;
        int                   ix;
        bit                   ok;
        logic [DATA_BITS-1:0] w;
        @(negedge clk);
        e    = edge_cnt + 1;
        csn  = 1'b0;
        rasn = 1'b1;
        casn = 1'b1;
        wen  = '1;
        a    = ROW_BITS'(av);
        d    = dv;
        case (k)
            K_DESEL:  begin csn = 1'b1; rasn = 1'($urandom); casn = 1'($urandom); wen = LANES'($urandom); end
            K_ACT:    rasn = 1'b0;
            K_RD:     casn = 1'b0;
            K_WR:     begin casn = 1'b0; wen = wv; end
            K_PRE:    begin rasn = 1'b0; wen = '0; end
            K_BAD_RC: begin rasn = 1'b0; casn = 1'b0; wen = wv; end
            K_BAD_WE: begin rasn = 1'b0; wen = wv; end
            default:  ;
        endcase
        ok = 1'b1;
        case (k)
            K_ACT: begin
                if (!m_open && e >= m_pre_t + T_RP) begin
                    m_open  = 1'b1;
                    m_row   = av % (1 << ROW_BITS);
                    m_act_t = e;
                end else ok = 1'b0;
            end
            K_RD, K_WR: begin
                if (m_open && e >= m_act_t + T_RCD) begin
                    ix = idx_of(m_row, av);
                    if (k == K_RD) begin
                        exp_rd.push_back('{due: e + CAS_LAT, data: mem_m[ix]});
                    end else begin
                        w = mem_m.exists(ix) ? mem_m[ix] : '0;
                        for (int i = 0; i < LANES; i++)
                            if (!wv[i]) w[i*8 +: 8] = dv[i*8 +: 8];
                        mem_m[ix] = w;
                    end
                end else ok = 1'b0;
            end
            K_PRE: begin
                if (m_open) begin
                    if (e >= m_act_t + T_RCD) begin
                        m_open  = 1'b0;
                        m_pre_t = e;
                    end else ok = 1'b0;
                end else if (e < m_pre_t + T_RP) ok = 1'b0;
            end
            K_BAD_RC, K_BAD_WE: ok = 1'b0;
            default: ;
        endcase
        if (!ok) exp_err[e] = 1'b1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) issue(K_NOP, 0, '0, '1);
    endtask

    task automatic do_reset(int cycles);
        @(negedge clk);
        csn  = 1'b1;
        rasn = 1'b1;
        casn = 1'b1;
        wen  = '1;
        rst  = 1'b0;
        exp_rd.delete();
        exp_q   = '0;
        m_open  = 1'b0;
        m_act_t = -1000;
        m_pre_t = -1000;
        repeat (cycles) @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: outputs of edge e are sampled just after the following falling edge.
    initial begin
        int e;
        bit ev;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                chk("reset_valid", DATA_BITS'(valid), '0);
                chk("reset_q", q, '0);
                chk("reset_err", DATA_BITS'(err), '0);
            end else begin
                e  = edge_cnt;
                ev = (exp_rd.size() > 0) && (exp_rd[0].due == e);
                if (ev) begin
                    exp_q = exp_rd[0].data;
                    void'(exp_rd.pop_front());
                end
                chk("valid", DATA_BITS'(valid), DATA_BITS'(ev));
                chk("q", q, exp_q);
                chk("cmd_err", DATA_BITS'(err), DATA_BITS'(exp_err.exists(e)));
            end
        end
    end

    initial begin
        kind_t                k;
        int                   r;
        int                   av;
        int                   ix;
        logic [DATA_BITS-1:0] dv;
        logic [LANES-1:0]     wv;

        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Full write then read, followed by a partial-lane write
        issue(K_ACT, 'h003, '0, '1);
        idle(4);
        issue(K_WR, 'h010, 32'hDEADBEEF, 4'b0000);
        issue(K_RD, 'h010, '0, '1);
        idle(6);
        issue(K_WR, 'h010, 32'h00001234, 4'b1100);
        issue(K_RD, 'h010, '0, '1);
        idle(6);

        // Back-to-back reads, with a same-index write right behind the first
        for (int i = 0; i < 4; i++) issue(K_WR, i, DATA_BITS'((i + 1) * 'h11), 4'b0000);
        for (int i = 0; i < 4; i++) issue(K_RD, i, '0, '1);
        issue(K_RD, 0, '0, '1);
        issue(K_WR, 0, 32'hCAFEF00D, 4'b0000);
        idle(7);

        // Precharge/activate timing, early column command, illegal encodings
        issue(K_PRE, 0, '0, '0);
        idle(2);
        issue(K_ACT, 'h003, '0, '1);
        issue(K_NOP, 0, '0, '1);
        issue(K_ACT, 'h003, '0, '1);
        idle(3);
        issue(K_RD, 'h010, '0, '1);
        issue(K_RD, 'h010, '0, '1);
        issue(K_BAD_RC, 0, '0, '1);
        issue(K_ACT, 'h001, '0, '1);
        issue(K_RD, 'h402, '0, '1);
        issue(K_PRE, 0, '0, '0);
        idle(6);
        issue(K_BAD_WE, 0, '0, 4'b0101);
        issue(K_PRE, 0, '0, '0);

        // Reset with reads in flight
        issue(K_ACT, 'h003, '0, '1);
        idle(4);
        issue(K_RD, 2, '0, '1);
        idle(2);
        do_reset(2);
        idle(CAS_LAT + 2);
        issue(K_RD, 2, '0, '1);
        idle(2);

        for (int n = 0; n < 800; n++) begin
            r  = int'($urandom_range(99));
            av = int'($urandom_range(15)) + (int'($urandom_range(1)) << COL_BITS);
            dv = $urandom;
            wv = LANES'($urandom);
            if      (r < 30) k = K_NOP;
            else if (r < 38) k = K_DESEL;
            else if (r < 47) k = K_ACT;
            else if (r < 55) k = K_PRE;
            else if (r < 76) k = K_RD;
            else if (r < 94) k = K_WR;
            else if (r < 97) k = K_BAD_RC;
            else             k = K_BAD_WE;
            if (k == K_ACT) av = int'($urandom_range((1 << ROW_BITS) - 1));
            ix = idx_of(m_row, av);
            if (k == K_RD && !mem_m.exists(ix)) k = K_WR;
            if (k == K_WR && (!mem_m.exists(ix) || wv == '1)) wv = '0;
            if (k == K_BAD_WE) while (wv == '1 || wv == '0) wv = LANES'($urandom);
            issue(k, av, dv, wv);
        end

        idle(CAS_LAT + 3);
        @(negedge clk);
        #2;
        chk("drain", DATA_BITS'(exp_rd.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dram_cmd_responder.md
Name: dram_cmd_responder

Overview:
- Synthesizable DRAM device model that sits at the far end of the DRAM command bus (CSn/RASn/CASn/WEn/A/D to Q/valid) driven by the AXI-to-DRAM wrapper.
- Decodes ACT/READ/WRITE/PRE commands and tracks one open row.
- Enforces activate-to-column and precharge timing.
- Returns read data after a fixed CAS latency with a one-cycle valid strobe. Used in system simulation and FPGA bring-up in place of the external DRAM.

Parameters:
- DATA_BITS, 32, data/Q width; WEn has DATA_BITS/8 lanes.
- ROW_BITS, 11, width of DRAM_A; the row is latched from A at ACT.
- COL_BITS, 10, column bits taken from A[COL_BITS-1:0] at READ/WRITE.
- MEM_ADDR_BITS, 12, backing array depth 2^MEM_ADDR_BITS words; index = low MEM_ADDR_BITS of {row,col}.
- T_RCD, 5, cycles from accepted ACT until a READ/WRITE is accepted.
- T_RP, 5, cycles from accepted PRE until an ACT is accepted.
- CAS_LAT, 5, read latency in cycles (range 1..15).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- DRAM_CSn  in  1  chip select, active low; 1 = NOP
- DRAM_RASn  in  1  row strobe, active low
- DRAM_CASn  in  1  column strobe, active low
- DRAM_WEn  in  DATA_BITS/8  per-byte write enable, active low
- DRAM_A  in  ROW_BITS  row address (ACT) / column address (READ/WRITE)
- DRAM_D  in  DATA_BITS  write data
- DRAM_Q  out  DATA_BITS  read data; holds the last returned word
- DRAM_valid  out  1  one-cycle strobe, DRAM_Q valid
- cmd_err  out  1  one-cycle pulse, illegal or timing-violating command ignored

Behaviour:
- Reset (rst=0, async):
  - state=CLOSED, counters 0, read pipeline cleared.
  - DRAM_Q=0, DRAM_valid=0, cmd_err=0.
  - Memory array is not reset.
- Command decode, sampled at the rising edge only when CSn=0:
  - ACT: RASn=0, CASn=1, WEn all 1.
  - READ: RASn=1, CASn=0, WEn all 1.
  - WRITE: RASn=1, CASn=0, any WEn bit 0.
  - PRE: RASn=0, CASn=1, WEn all 0.
  - NOP: RASn=1, CASn=1.
  - Any other combination (RASn=0 with CASn=0; RASn=0 with partial WEn) is illegal.
- States: CLOSED, ACTIVATING, OPEN, PRECHARGING.
  - CLOSED: ACT latches row=A and loads cnt=T_RCD-1, then goes to ACTIVATING. PRE is a legal no-op. READ/WRITE are errors.
  - ACTIVATING: cnt decrements each cycle; at cnt=0 go to OPEN. Any non-NOP command is an error and is ignored; the count continues.
  - OPEN: READ and WRITE are accepted every cycle. PRE loads cnt=T_RP-1 and goes to PRECHARGING. ACT is an error (row stays open).
  - PRECHARGING: counts down to CLOSED. Any non-NOP command is an error.
- Timing consequence (T_RCD=5): ACT at edge t0 makes READ/WRITE first legal at edge t0+5. PRE at t0 makes ACT first legal at t0+5.
- WRITE: at the sampling edge, each lane i with WEn[i]=0 updates mem[idx] byte i from D. Lanes with WEn[i]=1 are unchanged.
- READ:
  - mem[idx] is read at the sampling edge t0 and carried through a CAS_LAT-deep pipeline.
  - DRAM_Q/DRAM_valid are registered at edge t0+CAS_LAT, with valid high for exactly one cycle.
  - Back-to-back READs pipeline with no bubble.
  - A WRITE at t0+1 to the same index does not alter the data already in flight.
- Errors: cmd_err is registered and high for the one cycle after the offending edge. State, memory and pipeline are unaffected.
- PRE while reads are in flight: those reads still complete.
- Reset mid-operation: in-flight reads are dropped; no valid is issued after reset release.
- A beyond COL_BITS is ignored for column commands. The row uses all ROW_BITS.

Test Plan:
- After reset: ACT row 0x003 at t0, WRITE col 0x010 D=0xDEADBEEF WEn=0000 at t0+5, READ col 0x010 at t0+6 -> valid=1 at t0+11, Q=0xDEADBEEF; cmd_err never set.
- Partial write WEn=1100, D=0x00001234 over 0xDEADBEEF, then READ -> Q=0xDEAD1234.
- READ at t0+4 after ACT at t0 -> cmd_err pulse at t0+5, no valid ever. READ at t0+5 -> accepted.
- Four back-to-back READs at cols 0..3 holding 0x11,0x22,0x33,0x44 -> valid high for 4 consecutive cycles with Q in that order; Q holds 0x44 afterwards.
- PRE at t1 then ACT at t1+3 -> cmd_err; ACT at t1+5 -> accepted. RASn=0,CASn=0 in OPEN -> cmd_err, row still open, next READ valid.
- Pulse rst low 2 cycles after a READ -> Q=0, valid stays 0 through t0+CAS_LAT+2, state CLOSED (READ now flags cmd_err).
